// File: rtl/rhd_spi_slave_if.sv
// Pin and sideband bundle between the RHD2164 emulator and its SPI master/host.
// The slave modport is the device view; the master modport drives the SPI pins and response words.
interface rhd_spi_slave_if;
  logic        i_sclk;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_miso;
  logic [15:0] i_tx_a;
  logic [15:0] i_tx_b;
  logic        i_tx_ddr;
  logic        o_load;
  logic [15:0] o_cmd;
  logic        o_cmd_valid;
  logic        o_frame_err;
  logic        o_busy;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_tx_a, i_tx_b, i_tx_ddr,
    output o_miso, o_load, o_cmd, o_cmd_valid, o_frame_err, o_busy
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_tx_a, i_tx_b, i_tx_ddr,
    input  o_miso, o_load, o_cmd, o_cmd_valid, o_frame_err, o_busy
  );
endinterface

// File: rtl/rhd_spi_slave.sv
// Oversampled SPI responder emulating an RHD2164: captures 16-bit commands on MOSI
// and returns one word (normal) or two interleaved words A/B (DDR) on MISO.
module rhd_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rhd_spi_slave_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  // NOTE: CS_n history resets low, so a CS_n already low when reset releases
  // produces no cs_fall and cannot start a frame in the middle of a transfer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
      sclk_hist <= sclk_sync[LAST];
      cs_hist   <= cs_sync[LAST];
    end
  end

  assign sclk_s   = sclk_sync[LAST];
  assign cs_s     = cs_sync[LAST];
  assign mosi_s   = mosi_sync[LAST];
  assign cs_fall  =  cs_hist & ~cs_s;
  assign cs_rise  = ~cs_hist &  cs_s;
  assign sck_rise = ~sclk_hist &  sclk_s;
  assign sck_fall =  sclk_hist & ~sclk_s;

  state_t      state, state_d;
  logic [4:0]  rc, rc_d, fc, fc_d;
  logic [15:0] shreg, shreg_d;
  logic [15:0] cmd, cmd_d;
  logic [15:0] sh_a, sh_a_d, sh_b, sh_b_d;
  logic        sh_ddr, sh_ddr_d;
  logic        miso, miso_d;
  logic        load, load_d;
  logic        cmd_valid, cmd_valid_d;
  logic        frame_err, frame_err_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      rc        <= '0;
      fc        <= '0;
      shreg     <= '0;
      cmd       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_ddr    <= 1'b0;
      miso      <= 1'b0;
      load      <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      rc        <= rc_d;
      fc        <= fc_d;
      shreg     <= shreg_d;
      cmd       <= cmd_d;
      sh_a      <= sh_a_d;
      sh_b      <= sh_b_d;
      sh_ddr    <= sh_ddr_d;
      miso      <= miso_d;
      load      <= load_d;
      cmd_valid <= cmd_valid_d;
      frame_err <= frame_err_d;
    end
  end

  // NOTE: every next-value is given a hold/default first so no path through the
  // case statement leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d     = state;
    rc_d        = rc;
    fc_d        = fc;
    shreg_d     = shreg;
    cmd_d       = cmd;
    sh_a_d      = sh_a;
    sh_b_d      = sh_b;
    sh_ddr_d    = sh_ddr;
    miso_d      = miso;
    load_d      = 1'b0;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          sh_a_d   = bus.i_tx_a;
          sh_b_d   = bus.i_tx_b;
          sh_ddr_d = bus.i_tx_ddr;
          load_d   = 1'b1;
          rc_d     = '0;
          fc_d     = '0;
          // Normal mode presents A[15] before the first SCLK rise; DDR waits for rise 1.
          miso_d   = bus.i_tx_ddr ? 1'b0 : bus.i_tx_a[15];
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (sck_rise && rc < 5'd16) begin
            shreg_d = {shreg[14:0], mosi_s};
            rc_d    = rc + 5'd1;
            if (sh_ddr) miso_d = sh_a[4'd15 - rc[3:0]];
            if (rc == 5'd15) begin
              cmd_d       = {shreg[14:0], mosi_s};
              cmd_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
          end
          if (sck_fall && fc < 5'd16) begin
            fc_d = fc + 5'd1;
            if (sh_ddr)          miso_d = sh_b[4'd15 - fc[3:0]];
            else if (fc < 5'd15) miso_d = sh_a[4'd14 - fc[3:0]];
          end
        end
      end

      ST_DONE: begin
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sck_fall && fc == 5'd15) begin
          // Falling edge 16: DDR still owes B[0]; normal mode parks MISO low.
          fc_d   = 5'd16;
          miso_d = sh_ddr ? sh_b[0] : 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_miso      = miso;
  assign bus.o_load      = load;
  assign bus.o_cmd       = cmd;
  assign bus.o_cmd_valid = cmd_valid;
  assign bus.o_frame_err = frame_err;
  assign bus.o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rhd_spi_slave.sv
// Self-checking bench for rhd_spi_slave: a bit-banged SPI master plus a word-level
// reference (expected response = words present at CS_n fall, expected command = word sent).
module tb_rhd_spi_slave;

  localparam int H = 6;  // SCLK half-period in i_clk cycles

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  rhd_spi_slave_if bus ();

  rhd_spi_slave #(.SYNC_STAGES(2)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_load   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic [15:0] last_cmd = 16'h0000;

  always @(negedge i_clk) begin
    if (bus.o_load)      n_load++;
    if (bus.o_cmd_valid) n_valid++;
    if (bus.o_frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // One SPI frame. nrise < 16 ends the frame short; reset_at > 0 pulses reset after that falling edge.
  task automatic run_frame(input string tag, input logic [15:0] cmd, input int nrise,
                           input logic [15:0] a, input logic [15:0] b, input logic ddr,
                           input bit mid_change, input int reset_at);
    int l0, v0, e0;
    logic [15:0] da, db;
    bit full;
    l0 = n_load; v0 = n_valid; e0 = n_err;
    da = '0; db = '0;
    bus.i_tx_a = a; bus.i_tx_b = b; bus.i_tx_ddr = ddr;
    bus.i_mosi = cmd[15];
    wait_clk(2);
    bus.i_cs_n = 1'b0;
    wait_clk(8);
    check({tag, ":busy_in_frame"}, 32'(bus.o_busy), 32'd1);
    for (int k = 1; k <= nrise; k++) begin
      if (!ddr)        da[16-k] = bus.o_miso;
      else if (k >= 2) db[17-k] = bus.o_miso;
      bus.i_sclk = 1'b1;
      wait_clk(H);
      if (ddr) da[16-k] = bus.o_miso;
      bus.i_sclk = 1'b0;
      if (k < 16) bus.i_mosi = cmd[15-k];
      if (mid_change && k == 4) begin
        bus.i_tx_a   = 16'($urandom);
        bus.i_tx_b   = 16'($urandom);
        bus.i_tx_ddr = 1'($urandom);
      end
      if (reset_at == k) begin
        i_rst = 1'b0;
        #1;
        check({tag, ":rst_miso"},  32'(bus.o_miso),      32'd0);
        check({tag, ":rst_cmd"},   32'(bus.o_cmd),       32'd0);
        check({tag, ":rst_valid"}, 32'(bus.o_cmd_valid), 32'd0);
        check({tag, ":rst_load"},  32'(bus.o_load),      32'd0);
        check({tag, ":rst_err"},   32'(bus.o_frame_err), 32'd0);
        check({tag, ":rst_busy"},  32'(bus.o_busy),      32'd0);
        last_cmd = 16'h0000;
        wait_clk(3);
        i_rst = 1'b1;
      end
      wait_clk(H);
    end
    bus.i_cs_n = 1'b1;
    wait_clk(8);

    full = (nrise == 16) && (reset_at == 0);
    if (full) last_cmd = cmd;
    check({tag, ":load_pulses"},  32'(n_load - l0),  32'd1);
    check({tag, ":valid_pulses"}, 32'(n_valid - v0), full ? 32'd1 : 32'd0);
    check({tag, ":err_pulses"},   32'(n_err - e0),
          (nrise < 16 && reset_at == 0) ? 32'd1 : 32'd0);
    check({tag, ":cmd"},          32'(bus.o_cmd),    32'(last_cmd));
    check({tag, ":idle_miso"},    32'(bus.o_miso),   32'd0);
    check({tag, ":idle_busy"},    32'(bus.o_busy),   32'd0);
    if (full) begin
      check({tag, ":dout_a"}, 32'(da), 32'(a));
      if (ddr) check({tag, ":dout_b_15_1"}, 32'(db[15:1]), 32'(b[15:1]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, v0;
    bus.i_sclk = 1'b0; bus.i_cs_n = 1'b1; bus.i_mosi = 1'b0;
    bus.i_tx_a = 16'h0; bus.i_tx_b = 16'h0; bus.i_tx_ddr = 1'b0;
    wait_clk(2);
    check("reset:miso",  32'(bus.o_miso),      32'd0);
    check("reset:cmd",   32'(bus.o_cmd),       32'd0);
    check("reset:valid", 32'(bus.o_cmd_valid), 32'd0);
    check("reset:load",  32'(bus.o_load),      32'd0);
    check("reset:err",   32'(bus.o_frame_err), 32'd0);
    check("reset:busy",  32'(bus.o_busy),      32'd0);
    i_rst = 1'b1;
    wait_clk(6);

    run_frame("normal", 16'hC0FF, 16, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 0);
    run_frame("ddr",    16'h0000, 16, 16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 0);
    run_frame("short",  16'hBEEF, 8,  16'h7777, 16'h8888, 1'b0, 1'b0, 0);

    l0 = n_load; v0 = n_valid;
    for (int i = 1; i <= 3; i++)
      run_frame($sformatf("b2b%0d", i), 16'($urandom), 16, 16'(i), 16'($urandom),
                1'(i == 2), 1'b0, 0);
    check("b2b:load_total",  32'(n_load - l0),  32'd3);
    check("b2b:valid_total", 32'(n_valid - v0), 32'd3);

    run_frame("mid_normal", 16'h1357, 16, 16'hCAFE, 16'h0F0F, 1'b0, 1'b1, 0);
    run_frame("mid_ddr",    16'h2468, 16, 16'h3C3C, 16'hF00D, 1'b1, 1'b1, 0);

    run_frame("reset_mid",  16'hDEAD, 16, 16'h4321, 16'h1111, 1'b0, 1'b0, 5);
    run_frame("after_rst",  16'h6A6A, 16, 16'h9876, 16'h5555, 1'b1, 1'b0, 0);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("rand%0d", i), 16'($urandom), 16, 16'($urandom),
                16'($urandom), 1'($urandom), 1'($urandom), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
